// File: rtl/load_store_unit.sv
// Load/store unit: one outstanding data-memory op, registered request, extended load result.
// Define LSU_MISALIGN_TRAP_EN to trap misaligned accesses instead of rounding the offset down.
module load_store_unit #(
    parameter int DataWidth     = 32,
    parameter int AddrWidth     = 32,
    parameter int TimeoutCycles = 255
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic                   req_load,
    input  logic [2:0]             fun3,
    input  logic [AddrWidth-1:0]   addr,
    input  logic [DataWidth-1:0]   wdata,
    output logic                   rsp_valid,
    output logic [DataWidth-1:0]   rsp_rdata,
    output logic                   rsp_misalign,
    output logic                   rsp_err,
    output logic                   mem_req,
    output logic                   mem_we,
    output logic [AddrWidth-1:0]   mem_addr,
    output logic [DataWidth/8-1:0] mem_mask,
    output logic [DataWidth-1:0]   mem_wdata,
    input  logic                   mem_gnt,
    input  logic                   mem_rvalid,
    input  logic [DataWidth-1:0]   mem_rdata
);
    localparam int NumBytes = DataWidth / 8;
    localparam int OffW     = $clog2(NumBytes);
    localparam int CntW     = $clog2(TimeoutCycles + 1);
    localparam logic [CntW-1:0] CntLimit = CntW'(TimeoutCycles);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_e;

    state_e                state_q, state_d;
    logic [CntW-1:0]       cnt_q, cnt_d;
    logic                  is_load_q, is_load_d;
    logic [2:0]            fun3_q, fun3_d;
    logic [OffW-1:0]       off_q, off_d;
    logic                  mem_req_q, mem_req_d;
    logic                  mem_we_q, mem_we_d;
    logic [AddrWidth-1:0]  mem_addr_q, mem_addr_d;
    logic [NumBytes-1:0]   mem_mask_q, mem_mask_d;
    logic [DataWidth-1:0]  mem_wdata_q, mem_wdata_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [DataWidth-1:0]  rsp_rdata_q, rsp_rdata_d;
    logic                  rsp_misalign_q, rsp_misalign_d;
    logic                  rsp_err_q, rsp_err_d;

    // Decode of the incoming op
    logic [3:0]           nbytes;
    logic [OffW-1:0]      lsb_mask, in_off, aligned_off;
    logic                 op_legal;
    logic [NumBytes-1:0]  lane_mask;
    logic [DataWidth-1:0] lane_bits, wdata_lane;

    always_comb begin
        nbytes      = 4'd1 << fun3[1:0];
        lsb_mask    = OffW'(nbytes - 4'd1);
        in_off      = addr[OffW-1:0];
        aligned_off = in_off & ~lsb_mask;
        lane_mask   = NumBytes'((9'd1 << nbytes) - 9'd1) << aligned_off;
        for (int i = 0; i < NumBytes; i++) begin
            lane_bits[8*i +: 8] = {8{lane_mask[i]}};
        end
        wdata_lane = (wdata << {aligned_off, 3'b000}) & lane_bits;
        case (fun3)
            3'b000, 3'b001, 3'b010: op_legal = 1'b1;
            3'b100, 3'b101:         op_legal = req_load;
            3'b011:                 op_legal = (DataWidth == 64);
            3'b110:                 op_legal = req_load && (DataWidth == 64);
            default:                op_legal = 1'b0;
        endcase
    end

`ifdef LSU_MISALIGN_TRAP_EN
    logic op_misaligned;
    assign op_misaligned = (in_off & lsb_mask) != '0;
`endif

    // Load extraction: the top kept bit is the sign when funct3[2] is clear.
    logic [3:0]           ld_nbytes;
    logic [DataWidth-1:0] rdata_shifted, keep_bits, load_ext;
    logic                 ld_sign;

    always_comb begin
        ld_nbytes     = 4'd1 << fun3_q[1:0];
        rdata_shifted = mem_rdata >> {off_q, 3'b000};
        for (int i = 0; i < NumBytes; i++) begin
            keep_bits[8*i +: 8] = {8{i < int'(ld_nbytes)}};
        end
        ld_sign  = !fun3_q[2] && |(rdata_shifted & keep_bits & ~(keep_bits >> 1));
        load_ext = (rdata_shifted & keep_bits) | (ld_sign ? ~keep_bits : '0);
    end

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves one unassigned (no latches).
        state_d        = state_q;
        cnt_d          = cnt_q;
        is_load_d      = is_load_q;
        fun3_d         = fun3_q;
        off_d          = off_q;
        mem_req_d      = 1'b0;
        mem_we_d       = 1'b0;
        mem_addr_d     = '0;
        mem_mask_d     = '0;
        mem_wdata_d    = '0;
        rsp_valid_d    = 1'b0;
        rsp_rdata_d    = '0;
        rsp_misalign_d = 1'b0;
        rsp_err_d      = 1'b0;
        case (state_q)
            IDLE: if (req_valid) begin
                is_load_d = req_load;
                fun3_d    = fun3;
                off_d     = aligned_off;
                if (!op_legal) begin
                    state_d     = RESP;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                end
`ifdef LSU_MISALIGN_TRAP_EN
                else if (op_misaligned) begin
                    state_d        = RESP;
                    rsp_valid_d    = 1'b1;
                    rsp_misalign_d = 1'b1;
                end
`endif
                else begin
                    state_d     = REQ;
                    cnt_d       = '0;
                    mem_req_d   = 1'b1;
                    mem_we_d    = !req_load;
                    mem_addr_d  = {addr[AddrWidth-1:OffW], {OffW{1'b0}}};
                    mem_mask_d  = lane_mask;
                    mem_wdata_d = req_load ? '0 : wdata_lane;
                end
            end
            REQ: begin
                cnt_d = cnt_q + 1'b1;
                if (mem_gnt) begin
                    cnt_d = '0;
                    if (is_load_q) begin
                        state_d = WAIT;
                    end else begin
                        state_d     = RESP;
                        rsp_valid_d = 1'b1;
                    end
                end else if (cnt_q == CntLimit) begin
                    state_d     = RESP;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                end else begin
                    mem_req_d   = 1'b1;
                    mem_we_d    = mem_we_q;
                    mem_addr_d  = mem_addr_q;
                    mem_mask_d  = mem_mask_q;
                    mem_wdata_d = mem_wdata_q;
                end
            end
            WAIT: begin
                cnt_d = cnt_q + 1'b1;
                if (mem_rvalid) begin
                    state_d     = RESP;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = load_ext;
                end else if (cnt_q == CntLimit) begin
                    state_d     = RESP;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every flop samples the pre-edge values.
        if (rst) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            is_load_q      <= 1'b0;
            fun3_q         <= '0;
            off_q          <= '0;
            mem_req_q      <= 1'b0;
            mem_we_q       <= 1'b0;
            mem_addr_q     <= '0;
            mem_mask_q     <= '0;
            mem_wdata_q    <= '0;
            rsp_valid_q    <= 1'b0;
            rsp_rdata_q    <= '0;
            rsp_misalign_q <= 1'b0;
            rsp_err_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            is_load_q      <= is_load_d;
            fun3_q         <= fun3_d;
            off_q          <= off_d;
            mem_req_q      <= mem_req_d;
            mem_we_q       <= mem_we_d;
            mem_addr_q     <= mem_addr_d;
            mem_mask_q     <= mem_mask_d;
            mem_wdata_q    <= mem_wdata_d;
            rsp_valid_q    <= rsp_valid_d;
            rsp_rdata_q    <= rsp_rdata_d;
            rsp_misalign_q <= rsp_misalign_d;
            rsp_err_q      <= rsp_err_d;
        end
    end

    assign req_ready    = (state_q == IDLE) && !rst;
    assign mem_req      = mem_req_q;
    assign mem_we       = mem_we_q;
    assign mem_addr     = mem_addr_q;
    assign mem_mask     = mem_mask_q;
    assign mem_wdata    = mem_wdata_q;
    assign rsp_valid    = rsp_valid_q;
    assign rsp_rdata    = rsp_rdata_q;
    assign rsp_misalign = rsp_misalign_q;
    assign rsp_err      = rsp_err_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: transaction-level timeline model, per-cycle compare.
module tb_load_store_unit;
    localparam int DW = 32;
    localparam int AW = 32;
    localparam int TO = 4;
    localparam int NB = DW / 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid, req_ready, req_load;
    logic [2:0]    fun3;
    logic [AW-1:0] addr, mem_addr;
    logic [DW-1:0] wdata, rsp_rdata, mem_wdata, mem_rdata;
    logic          rsp_valid, rsp_misalign, rsp_err;
    logic          mem_req, mem_we, mem_gnt, mem_rvalid;
    logic [NB-1:0] mem_mask;

    always #5 clk = ~clk;

    load_store_unit #(.DataWidth(DW), .AddrWidth(AW), .TimeoutCycles(TO)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_load(req_load),
        .fun3(fun3), .addr(addr), .wdata(wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .rsp_misalign(rsp_misalign), .rsp_err(rsp_err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_mask(mem_mask), .mem_wdata(mem_wdata),
        .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model (spec rules, plain arithmetic) ----------------
    function automatic int sz(input logic [2:0] f3);
        return 1 << f3[1:0];
    endfunction

    function automatic bit legal(input bit ld, input logic [2:0] f3);
        if (ld) return (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) || (DW == 64 && f3 inside {3'd3, 3'd6});
        return (f3 inside {3'd0, 3'd1, 3'd2}) || (DW == 64 && f3 == 3'd3);
    endfunction

    function automatic bit misal(input logic [AW-1:0] a, input logic [2:0] f3);
        return (int'(a % NB) % sz(f3)) != 0;
    endfunction

    function automatic bit trapped(input logic [AW-1:0] a, input logic [2:0] f3);
`ifdef LSU_MISALIGN_TRAP_EN
        return misal(a, f3);
`else
        return 1'b0;
`endif
    endfunction

    function automatic int eff_off(input logic [AW-1:0] a, input logic [2:0] f3);
        int off;
        off = int'(a % NB);
        return off - (off % sz(f3));
    endfunction

    function automatic logic [NB-1:0] m_mask(input logic [AW-1:0] a, input logic [2:0] f3);
        longint m;
        m = ((longint'(1) << sz(f3)) - 1) << eff_off(a, f3);
        return NB'(m);
    endfunction

    function automatic logic [DW-1:0] m_wdata(input logic [DW-1:0] wd, input logic [AW-1:0] a, input logic [2:0] f3);
        logic [127:0] v, lim;
        lim = 128'(1) << (8 * sz(f3));
        v   = (128'(wd) & (lim - 1)) << (8 * eff_off(a, f3));
        return v[DW-1:0];
    endfunction

    function automatic logic [DW-1:0] m_load(input logic [DW-1:0] rd, input logic [AW-1:0] a, input logic [2:0] f3);
        logic [127:0] v, lim;
        lim = 128'(1) << (8 * sz(f3));
        v   = (128'(rd) >> (8 * eff_off(a, f3))) & (lim - 1);
        if (!f3[2] && v >= (lim >> 1)) v = v - lim;
        return v[DW-1:0];
    endfunction

    // ---------------- expectations and per-cycle compare ----------------
    logic          exp_ready, exp_mem_req, exp_we, exp_rsp_valid, exp_err, exp_mis;
    logic [AW-1:0] exp_addr;
    logic [NB-1:0] exp_mask;
    logic [DW-1:0] exp_wdata, exp_rdata;
    bit            chk_en = 1'b0;
    int            cur_k  = -1;

    bit            obs_req_seen;
    logic [AW-1:0] obs_addr;
    logic [NB-1:0] obs_mask;
    logic [DW-1:0] obs_wdata, obs_rdata;
    logic          obs_err, obs_mis;
    int            obs_rsp_cnt, obs_rsp_cycle;

    always @(negedge clk) begin
        if (chk_en) begin
            check("req_ready",    64'(req_ready),    64'(exp_ready));
            check("mem_req",      64'(mem_req),      64'(exp_mem_req));
            check("mem_we",       64'(mem_we),       64'(exp_we));
            check("mem_addr",     64'(mem_addr),     64'(exp_addr));
            check("mem_mask",     64'(mem_mask),     64'(exp_mask));
            check("mem_wdata",    64'(mem_wdata),    64'(exp_wdata));
            check("rsp_valid",    64'(rsp_valid),    64'(exp_rsp_valid));
            check("rsp_rdata",    64'(rsp_rdata),    64'(exp_rdata));
            check("rsp_err",      64'(rsp_err),      64'(exp_err));
            check("rsp_misalign", 64'(rsp_misalign), 64'(exp_mis));
            if (mem_req === 1'b1) begin
                obs_req_seen = 1'b1;
                obs_addr     = mem_addr;
                obs_mask     = mem_mask;
                obs_wdata    = mem_wdata;
            end
            if (rsp_valid === 1'b1) begin
                obs_rsp_cnt++;
                obs_rsp_cycle = cur_k;
                obs_rdata     = rsp_rdata;
                obs_err       = rsp_err;
                obs_mis       = rsp_misalign;
            end
        end
    end

    function automatic bit rbit();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic exp_quiet(input bit rdy);
        exp_ready = rdy;  exp_mem_req = 0; exp_we = 0; exp_addr = '0; exp_mask = '0;
        exp_wdata = '0;   exp_rsp_valid = 0; exp_rdata = '0; exp_err = 0; exp_mis = 0;
    endtask

    task automatic clear_obs();
        obs_req_seen = 0; obs_addr = '0; obs_mask = '0; obs_wdata = '0; obs_rdata = '0;
        obs_err = 0; obs_mis = 0; obs_rsp_cnt = 0; obs_rsp_cycle = -1;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            exp_quiet(1); cur_k = -1;
            req_valid = 0; mem_gnt = rbit(); mem_rvalid = rbit(); mem_rdata = $urandom;
            step();
        end
    endtask

    // One op accepted in cycle 0. gd/rd: cycles until grant/rvalid; > TO means never.
    task automatic run_op(input bit ld, input logic [2:0] f3, input logic [AW-1:0] a,
                          input logic [DW-1:0] wd, input int gd, input int rd, input logic [DW-1:0] rdat);
        int rsp_k, req_end, rv_k;
        bit has_wait, e_err, e_mis;
        logic [DW-1:0] e_rdata;
        rv_k = -1; has_wait = 0; e_err = 0; e_mis = 0; e_rdata = '0; req_end = 0;
        if (!legal(ld, f3)) begin
            rsp_k = 1; e_err = 1;
        end else if (trapped(a, f3)) begin
            rsp_k = 1; e_mis = 1;
        end else if (gd > TO) begin
            req_end = 1 + TO; rsp_k = req_end + 1; e_err = 1;
        end else begin
            req_end = 1 + gd;
            if (!ld) begin
                rsp_k = req_end + 1;
            end else if (rd > TO) begin
                has_wait = 1; rsp_k = req_end + 1 + TO + 1; e_err = 1;
            end else begin
                has_wait = 1; rv_k = req_end + 1 + rd; rsp_k = rv_k + 1;
                e_rdata = m_load(rdat, a, f3);
            end
        end
        clear_obs();
        for (int k = 0; k <= rsp_k; k++) begin
            cur_k = k;
            exp_quiet(k == 0);
            if (k >= 1 && k <= req_end) begin
                exp_mem_req = 1;
                exp_we      = !ld;
                exp_addr    = a - AW'(a % NB);
                exp_mask    = m_mask(a, f3);
                exp_wdata   = ld ? '0 : m_wdata(wd, a, f3);
            end
            if (k == rsp_k) begin
                exp_rsp_valid = 1; exp_rdata = e_rdata; exp_err = e_err; exp_mis = e_mis;
            end
            if (k == 0) begin
                req_valid = 1; req_load = ld; fun3 = f3; addr = a; wdata = wd;
            end else begin
                req_valid = rbit(); req_load = rbit(); fun3 = 3'($urandom);
                addr = $urandom; wdata = $urandom;
            end
            if (k >= 1 && k <= req_end) mem_gnt = (k == 1 + gd);
            else mem_gnt = rbit();
            if (has_wait && k > req_end && k < rsp_k) mem_rvalid = (k == rv_k);
            else mem_rvalid = rbit();
            mem_rdata = (k == rv_k) ? rdat : DW'($urandom);
            step();
        end
    endtask

    initial begin
        bit            r_ld;
        logic [2:0]    r_f3;
        int            r_gd, r_rd;

        rst = 1; req_valid = 0; req_load = 0; fun3 = '0; addr = '0; wdata = '0;
        mem_gnt = 0; mem_rvalid = 0; mem_rdata = '0;
        clear_obs();
        step();
        exp_quiet(0); chk_en = 1;
        step();
        rst = 0;
        idle_cycles(2);

        // Pin the model against hand-computed values
        check("pin_lh",   64'(m_load(32'h8001_1234, 32'h2002, 3'b001)), 64'h0000_0000_FFFF_8001);
        check("pin_lhu",  64'(m_load(32'h8001_1234, 32'h2002, 3'b101)), 64'h0000_0000_0000_8001);
        check("pin_mask", 64'(m_mask(32'h1003, 3'b000)), 64'h8);
        check("pin_wd",   64'(m_wdata(32'h0000_00AB, 32'h1003, 3'b000)), 64'hAB00_0000);

        // sb to the top lane, immediate grant
        run_op(0, 3'b000, 32'h1003, 32'h0000_00AB, 0, 0, '0);
        check("sb_mask", 64'(obs_mask), 64'h8);
        check("sb_wdata", 64'(obs_wdata), 64'hAB00_0000);
        check("sb_addr", 64'(obs_addr), 64'h1000);
        check("sb_latency", 64'(obs_rsp_cycle), 64'd2);

        // lh / lhu of the same word
        run_op(1, 3'b001, 32'h2002, '0, 0, 0, 32'h8001_1234);
        check("lh_rdata", 64'(obs_rdata), 64'hFFFF_8001);
        check("lh_latency", 64'(obs_rsp_cycle), 64'd3);
        run_op(1, 3'b101, 32'h2002, '0, 0, 0, 32'h8001_1234);
        check("lhu_rdata", 64'(obs_rdata), 64'h0000_8001);

        // misaligned lw
        run_op(1, 3'b010, 32'h0001, '0, 0, 0, 32'hDEAD_BEEF);
`ifdef LSU_MISALIGN_TRAP_EN
        check("lw_mis_flag", 64'(obs_mis), 64'd1);
        check("lw_mis_latency", 64'(obs_rsp_cycle), 64'd1);
        check("lw_mis_no_req", 64'(obs_req_seen), 64'd0);
`else
        check("lw_mis_addr", 64'(obs_addr), 64'h0);
        check("lw_mis_mask", 64'(obs_mask), 64'hF);
        check("lw_mis_rdata", 64'(obs_rdata), 64'hDEAD_BEEF);
`endif

        // grant timeout and rvalid timeout
        run_op(1, 3'b010, 32'h0100, '0, TO + 1, 0, '0);
        check("gnt_to_latency", 64'(obs_rsp_cycle), 64'd6);
        check("gnt_to_err", 64'(obs_err), 64'd1);
        check("gnt_to_rdata", 64'(obs_rdata), 64'h0);
        run_op(1, 3'b010, 32'h0104, '0, 0, TO + 1, '0);
        check("rv_to_latency", 64'(obs_rsp_cycle), 64'd7);
        check("rv_to_err", 64'(obs_err), 64'd1);

        // illegal funct3 at 32 bits, illegal store
        run_op(1, 3'b011, 32'h0008, '0, 0, 0, '0);
        check("ld32_err", 64'(obs_err), 64'd1);
        check("ld32_latency", 64'(obs_rsp_cycle), 64'd1);
        check("ld32_no_req", 64'(obs_req_seen), 64'd0);
        run_op(0, 3'b100, 32'h0010, 32'h1234_5678, 0, 0, '0);
        check("st_f3_err", 64'(obs_err), 64'd1);

        // reset while a load waits for rvalid
        clear_obs();
        exp_quiet(1); cur_k = 0;
        req_valid = 1; req_load = 1; fun3 = 3'b010; addr = 32'h40; mem_gnt = 0; mem_rvalid = 0;
        step();
        exp_quiet(0); exp_mem_req = 1; exp_addr = 32'h40; exp_mask = '1;
        req_valid = 0; mem_gnt = 1;
        step();
        exp_quiet(0); mem_gnt = 0;
        step();
        exp_quiet(0); rst = 1;
        step();
        exp_quiet(0); mem_rvalid = 1; mem_rdata = 32'hCAFE_F00D;
        step();
        exp_quiet(1); rst = 0;
        step();
        idle_cycles(4);
        check("rst_no_rsp", 64'(obs_rsp_cnt), 64'd0);

        // randomized ops, back-to-back and with gaps
        for (int n = 0; n < 300; n++) begin
            r_ld = rbit();
            if ($urandom_range(0, 7) == 0) r_f3 = 3'($urandom);
            else r_f3 = 3'($urandom_range(0, 2)) | ((r_ld && rbit()) ? 3'b100 : 3'b000);
            r_gd = ($urandom_range(0, 7) == 0) ? TO + 1 : int'($urandom_range(0, TO - 1));
            r_rd = ($urandom_range(0, 7) == 0) ? TO + 1 : int'($urandom_range(0, TO - 1));
            run_op(r_ld, r_f3, $urandom, $urandom, r_gd, r_rd, $urandom);
            if (rbit()) idle_cycles(int'($urandom_range(1, 2)));
        end

        chk_en = 0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
